execute_cycle: RTL and testbench
================================

EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001: clk  input  1  single clock; all state updates on posedge clk.
REQ-002: rst  input  1  asynchronous, active-low reset; rst=0 clears the EX/MEM register immediately, independent of clk.
REQ-003: RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  input  1 each  E-stage control bits from decode.
REQ-004: ALUControlE  input  3  ALU operation select.
REQ-005: RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  input  32 each  operands, immediate and PCs from decode.
REQ-006: RD_E  input  5  destination register index.
REQ-007: ResultW  input  32  writeback-stage result, used for forwarding.
REQ-008: ForwardA_E, ForwardB_E  input  2 each  forwarding selects from the hazard unit.
REQ-009: PCSrcE  output  1  branch-taken indication to fetch; combinational.
REQ-010: PCTargetE  output  32  branch target to fetch; combinational.
REQ-011: RegWriteM, MemWriteM, ResultSrcM  output  1 each  registered control bits to memory stage.
REQ-012: RD_M  output  5  registered destination index.
REQ-013: ALUResultM, WriteDataM, PCPlus4M  output  32 each  registered datapath values.

Function
REQ-014: SrcA select by ForwardA_E: 00 -> RD1_E; 01 -> ResultW; 10 -> ALUResultM; 11 -> RD1_E.
REQ-015: Forwarded B value by ForwardB_E, using the same encoding on RD2_E; the result is WriteDataE.
REQ-016: SrcB = Imm_Ext_E when ALUSrcE=1, else WriteDataE.
REQ-017: The ALU shall implement these operations:
- 000: add SrcA+SrcB, modulo 2^32.
- 001: sub SrcA-SrcB, modulo 2^32.
- 010: AND.
- 011: OR.
- 101: signed set-less-than, result 32'h1 or 32'h0.
- Any other code: result 32'h0.
REQ-018: ZeroE = 1 iff the ALU result == 32'h0.
REQ-019: PCTargetE = PCE + Imm_Ext_E, modulo 2^32, with no overflow flag.
REQ-020: PCSrcE = BranchE & ZeroE, combinational in the same cycle; this covers beq only.
REQ-021: On each posedge clk with rst=1, the EX/MEM register shall capture:
- RegWriteM<=RegWriteE, MemWriteM<=MemWriteE, ResultSrcM<=ResultSrcE.
- RD_M<=RD_E.
- ALUResultM<=ALU result, WriteDataM<=WriteDataE, PCPlus4M<=PCPlus4E.
REQ-022: Latency: E-stage inputs appear on the M outputs exactly 1 cycle later; PCSrcE and PCTargetE have 0-cycle latency.
REQ-023: Forwarding selection 10 shall use the currently registered ALUResultM, i.e. the previous instruction's result (back-to-back dependency with no stall).
REQ-024: A simultaneous forward on A and B from different sources shall be resolved independently for each operand.
REQ-025: The block shall contain no stall or flush input; bubbles arrive as all-zero control bits from decode and shall propagate unchanged.

Reset
REQ-026: While rst=0, all M outputs shall be 0: RegWriteM, MemWriteM, ResultSrcM, RD_M=5'h00, ALUResultM, WriteDataM, PCPlus4M=32'h0.
REQ-027: Assertion of rst mid-operation shall clear all M outputs without waiting for clk; the first capture occurs on the first posedge after rst returns to 1.
REQ-028: PCSrcE and PCTargetE remain purely combinational during reset.

Verification
REQ-029: Add. Stimulus: RD1_E=5, RD2_E=7, ALUControlE=000, ALUSrcE=0, Forward=00, RD_E=3, RegWriteE=1. Response: after 1 clk, ALUResultM=12, RD_M=3, RegWriteM=1.
REQ-030: Branch taken. Stimulus: BranchE=1, RD1_E=RD2_E=9, ALUControlE=001, PCE=32'h100, Imm_Ext_E=32'hFFFFFFF8. Response: PCSrcE=1 and PCTargetE=32'hF8 in the same cycle.
REQ-031: Forwarding. Stimulus: cycle 1 add producing 20; cycle 2 ForwardA_E=10, RD1_E=0, RD2_E=1, add. Response: ALUResultM=21. Repeat with ForwardB_E=01, ResultW=100, RD1_E=1. Response: 101.
REQ-032: slt. Stimulus: RD1_E=32'hFFFFFFFF (-1), RD2_E=1, ALUControlE=101. Response: ALUResultM=1. Swap the operands. Response: 0.
REQ-033: Store path. Stimulus: ALUSrcE=1, Imm_Ext_E=8, RD1_E=32'h40, RD2_E=32'hABCD, MemWriteE=1. Response: ALUResultM=32'h48, WriteDataM=32'hABCD, MemWriteM=1.
REQ-034: Reset. Stimulus: drive rst=0 between clock edges while the M outputs are non-zero. Response: all M outputs are 0 before the next edge; after rst=1, the first posedge captures the current inputs.

Source files
------------

// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - execute stage: forwarding muxes, ALU, branch resolve, EX/MEM register
module execute_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        ALUSrcE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [4:0]  RD_E,
    input  logic [31:0] ResultW,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M
);

    logic [31:0] w_src_a;
    logic [31:0] w_write_data;
    logic [31:0] w_src_b;
    logic [31:0] w_alu_result;
    logic        w_zero;

    logic        r_reg_write;
    logic        r_mem_write;
    logic        r_result_src;
    logic [4:0]  r_rd;
    logic [31:0] r_alu_result;
    logic [31:0] r_write_data;
    logic [31:0] r_pc_plus4;

    // Operand forwarding; 10 takes the result held in EX/MEM (previous instruction)
    always_comb begin
        w_src_a = RD1_E;
        case (ForwardA_E)
            2'b01:   w_src_a = ResultW;
            2'b10:   w_src_a = r_alu_result;
            default: w_src_a = RD1_E;
        endcase
        w_write_data = RD2_E;
        case (ForwardB_E)
            2'b01:   w_write_data = ResultW;
            2'b10:   w_write_data = r_alu_result;
            default: w_write_data = RD2_E;
        endcase
    end

    assign w_src_b = ALUSrcE ? Imm_Ext_E : w_write_data;

    // ALU; unassigned codes yield zero so they also read as "zero" for branches
    always_comb begin
        w_alu_result = 32'h0;
        case (ALUControlE)
            3'b000:  w_alu_result = w_src_a + w_src_b;
            3'b001:  w_alu_result = w_src_a - w_src_b;
            3'b010:  w_alu_result = w_src_a & w_src_b;
            3'b011:  w_alu_result = w_src_a | w_src_b;
            3'b101:  w_alu_result = {31'h0, ($signed(w_src_a) < $signed(w_src_b))};
            default: w_alu_result = 32'h0;
        endcase
    end

    assign w_zero    = (w_alu_result == 32'h0);
    assign PCSrcE    = BranchE & w_zero;
    assign PCTargetE = PCE + Imm_Ext_E;

    // EX/MEM pipeline register, cleared asynchronously while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result_src <= 1'b0;
            r_rd         <= 5'h00;
            r_alu_result <= 32'h0;
            r_write_data <= 32'h0;
            r_pc_plus4   <= 32'h0;
        end else begin
            r_reg_write  <= RegWriteE;
            r_mem_write  <= MemWriteE;
            r_result_src <= ResultSrcE;
            r_rd         <= RD_E;
            r_alu_result <= w_alu_result;
            r_write_data <= w_write_data;
            r_pc_plus4   <= PCPlus4E;
        end
    end

    assign RegWriteM  = r_reg_write;
    assign MemWriteM  = r_mem_write;
    assign ResultSrcM = r_result_src;
    assign RD_M       = r_rd;
    assign ALUResultM = r_alu_result;
    assign WriteDataM = r_write_data;
    assign PCPlus4M   = r_pc_plus4;

endmodule

// File: tb/tb_execute_cycle.sv
// tb/tb_execute_cycle.sv - directed-vector bench for execute_cycle
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ResultW(ResultW),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
        ALUControlE = 3'b000; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0;
        PCPlus4E = 0; RD_E = 0; ResultW = 0; ForwardA_E = 2'b00; ForwardB_E = 2'b00;
    endtask

    task automatic test_reset();
        logic [103:0] m_all;
        clear_inputs();
        RegWriteE = 1; RD1_E = 32'h11; RD_E = 5'd7; PCPlus4E = 32'h44;
        rst = 1'b0;
        tick();
        m_all = {RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M};
        vectors++;
        if (m_all !== 104'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h want 0", m_all);
        end
        #2 rst = 1'b1;
    endtask

    task automatic test_add();
        clear_inputs();
        RD1_E = 5; RD2_E = 7; ALUControlE = 3'b000; RD_E = 5'd3; RegWriteE = 1;
        PCPlus4E = 32'h208; ResultSrcE = 1;
        tick();
        vectors++;
        if ({RegWriteM, RD_M, ALUResultM, WriteDataM, PCPlus4M, ResultSrcM, MemWriteM}
            !== {1'b1, 5'd3, 32'd12, 32'd7, 32'h208, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL add: reg=%b rd=%0d alu=%0d wd=%0d pc4=%h rs=%b mw=%b want 1 3 12 7 208 1 0",
                     RegWriteM, RD_M, ALUResultM, WriteDataM, PCPlus4M, ResultSrcM, MemWriteM);
        end
    endtask

    task automatic test_alu_ops();
        logic [2:0]  ops [6]  = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111};
        logic [31:0] a   [6]  = '{32'd5, 32'hF0F0, 32'hF0F0, 32'h1234, 32'h5, 32'h9};
        logic [31:0] b   [6]  = '{32'd7, 32'hFF00, 32'hFF00, 32'h1, 32'h6, 32'h9};
        logic [31:0] exp [6]  = '{32'hFFFFFFFE, 32'hF000, 32'hFFF0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            RD1_E = a[i]; RD2_E = b[i]; ALUControlE = ops[i];
            tick();
            vectors++;
            if (ALUResultM !== exp[i]) begin
                miscompares++;
                $display("FAIL alu_op_%b: got %h want %h", ops[i], ALUResultM, exp[i]);
            end
        end
    endtask

    task automatic test_branch();
        clear_inputs();
        BranchE = 1; RD1_E = 9; RD2_E = 9; ALUControlE = 3'b001;
        PCE = 32'h100; Imm_Ext_E = 32'hFFFFFFF8;
        #1;
        vectors++;
        if ({PCSrcE, PCTargetE} !== {1'b1, 32'hF8}) begin
            miscompares++;
            $display("FAIL branch_taken: pcsrc=%b target=%h want 1 000000f8", PCSrcE, PCTargetE);
        end
        RD2_E = 8;
        #1;
        vectors++;
        if (PCSrcE !== 1'b0) begin
            miscompares++;
            $display("FAIL branch_not_taken: pcsrc=%b want 0", PCSrcE);
        end
        BranchE = 0; RD2_E = 9;
        #1;
        vectors++;
        if (PCSrcE !== 1'b0) begin
            miscompares++;
            $display("FAIL branch_disabled: pcsrc=%b want 0", PCSrcE);
        end
        tick();
    endtask

    task automatic test_forward();
        clear_inputs();
        RD1_E = 10; RD2_E = 10;
        tick();
        ForwardA_E = 2'b10; RD1_E = 0; RD2_E = 1;
        tick();
        vectors++;
        if (ALUResultM !== 32'd21) begin
            miscompares++;
            $display("FAIL fwd_a_mem: got %0d want 21", ALUResultM);
        end
        ForwardA_E = 2'b00; ForwardB_E = 2'b01; ResultW = 100; RD1_E = 1; RD2_E = 5;
        tick();
        vectors++;
        if ({ALUResultM, WriteDataM} !== {32'd101, 32'd100}) begin
            miscompares++;
            $display("FAIL fwd_b_wb: alu=%0d wd=%0d want 101 100", ALUResultM, WriteDataM);
        end
        ForwardA_E = 2'b10; ForwardB_E = 2'b01; ResultW = 100; RD1_E = 0; RD2_E = 0;
        tick();
        vectors++;
        if (ALUResultM !== 32'd201) begin
            miscompares++;
            $display("FAIL fwd_both: got %0d want 201", ALUResultM);
        end
        ForwardA_E = 2'b11; ForwardB_E = 2'b10; RD1_E = 3; RD2_E = 0; ResultW = 7;
        tick();
        vectors++;
        if ({ALUResultM, WriteDataM} !== {32'd204, 32'd201}) begin
            miscompares++;
            $display("FAIL fwd_a11_b10: alu=%0d wd=%0d want 204 201", ALUResultM, WriteDataM);
        end
    endtask

    task automatic test_slt();
        clear_inputs();
        RD1_E = 32'hFFFFFFFF; RD2_E = 1; ALUControlE = 3'b101;
        tick();
        vectors++;
        if (ALUResultM !== 32'h1) begin
            miscompares++;
            $display("FAIL slt_neg_lt_pos: got %h want 1", ALUResultM);
        end
        RD1_E = 1; RD2_E = 32'hFFFFFFFF;
        tick();
        vectors++;
        if (ALUResultM !== 32'h0) begin
            miscompares++;
            $display("FAIL slt_pos_lt_neg: got %h want 0", ALUResultM);
        end
    endtask

    task automatic test_store();
        clear_inputs();
        ALUSrcE = 1; Imm_Ext_E = 8; RD1_E = 32'h40; RD2_E = 32'hABCD; MemWriteE = 1;
        tick();
        vectors++;
        if ({ALUResultM, WriteDataM, MemWriteM, RegWriteM} !== {32'h48, 32'hABCD, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL store: alu=%h wd=%h mw=%b rw=%b want 48 abcd 1 0",
                     ALUResultM, WriteDataM, MemWriteM, RegWriteM);
        end
    endtask

    task automatic test_bubble();
        clear_inputs();
        RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; RD_E = 5'd31;
        tick();
        clear_inputs();
        RD1_E = 2; RD2_E = 3;
        tick();
        vectors++;
        if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM} !== {3'b000, 5'd0, 32'd5}) begin
            miscompares++;
            $display("FAIL bubble: rw=%b mw=%b rs=%b rd=%0d alu=%0d want 0 0 0 0 5",
                     RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM);
        end
    endtask

    task automatic test_async_reset();
        logic [103:0] m_all;
        clear_inputs();
        RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; RD_E = 5'd9;
        RD1_E = 32'h30; RD2_E = 32'h5; PCPlus4E = 32'h1004;
        tick();
        #2 rst = 1'b0;
        #1;
        m_all = {RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M};
        vectors++;
        if (m_all !== 104'h0) begin
            miscompares++;
            $display("FAIL async_clear: got %h want 0", m_all);
        end
        clear_inputs();
        BranchE = 1; RD1_E = 4; RD2_E = 4; ALUControlE = 3'b001;
        PCE = 32'h2000; Imm_Ext_E = 32'h10;
        #1;
        vectors++;
        if ({PCSrcE, PCTargetE} !== {1'b1, 32'h2010}) begin
            miscompares++;
            $display("FAIL comb_in_reset: pcsrc=%b target=%h want 1 00002010", PCSrcE, PCTargetE);
        end
        tick();
        m_all = {RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M};
        vectors++;
        if (m_all !== 104'h0) begin
            miscompares++;
            $display("FAIL held_in_reset: got %h want 0", m_all);
        end
        rst = 1'b1;
        clear_inputs();
        RegWriteE = 1; RD_E = 5'd4; RD1_E = 32'h7; RD2_E = 32'h8; PCPlus4E = 32'h3004;
        tick();
        vectors++;
        if ({RegWriteM, RD_M, ALUResultM, WriteDataM, PCPlus4M}
            !== {1'b1, 5'd4, 32'hF, 32'h8, 32'h3004}) begin
            miscompares++;
            $display("FAIL first_capture: rw=%b rd=%0d alu=%h wd=%h pc4=%h want 1 4 f 8 3004",
                     RegWriteM, RD_M, ALUResultM, WriteDataM, PCPlus4M);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_branch();
        test_forward();
        test_slt();
        test_store();
        test_bubble();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
